// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the I/D cache to memory arbiter.
// Line/address widths follow the LC-3b cache types; arbiter state encoding lives here.
package cache_mem_arbiter_pkg;

    localparam int ADDR_W           = 16;
    localparam int DATA_W           = 128;
    localparam int SEL_W            = 16;
    localparam int BURST_W          = 4;
    localparam int DEF_MAX_D_BURST  = 4;

    typedef logic [ADDR_W-1:0]  lc3b_word;
    typedef logic [DATA_W-1:0]  lc3b_data;
    typedef logic [SEL_W-1:0]   lc3b_mem_wmask;
    typedef logic [BURST_W-1:0] arb_burst_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } lc3b_arb_state;

    function automatic arb_burst_t burst_inc(input arb_burst_t cur, input arb_burst_t max);
        return (cur >= max) ? max : cur + 1'b1;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// stb/cyc/resp/retry memory bus shared by the I-cache, D-cache and physical memory port.
// The requester side is the master; rdata/resp/retry flow back from the slave.
interface cache_mem_arbiter_if;
    import cache_mem_arbiter_pkg::*;

    lc3b_word      address;
    lc3b_data      wdata;
    logic          write;
    lc3b_mem_wmask byte_enable;
    logic          stb;
    logic          cyc;
    lc3b_data      rdata;
    logic          resp;
    logic          retry;

    modport master (
        output address, wdata, write, byte_enable, stb, cyc,
        input  rdata, resp, retry
    );

    modport slave (
        input  address, wdata, write, byte_enable, stb, cyc,
        output rdata, resp, retry
    );

endinterface

// File: rtl/cache_mem_arbiter_select.sv
// Combinational grant pick: D wins ties unless the waiting I side has hit the D burst cap.
// Zero latency; no state.
module cache_arb_select
    import cache_mem_arbiter_pkg::*;
#(
    parameter int MAX_D_BURST = DEF_MAX_D_BURST
) (
    input  logic       i_valid_i,
    input  logic       d_valid_i,
    input  arb_burst_t d_burst_i,
    output logic       grant_i_o,
    output logic       grant_d_o
);

    logic i_starved;

    assign i_starved = i_valid_i && (d_burst_i == BURST_W'(MAX_D_BURST));
    assign grant_d_o = d_valid_i && !i_starved;
    assign grant_i_o = i_valid_i && !grant_d_o;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Merges I-cache and D-cache line traffic onto one memory port, one transaction at a time.
// One IDLE cycle of arbitration per grant; requesters wait (stb/cyc held) until resp or retry.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int MAX_D_BURST = DEF_MAX_D_BURST
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_mem_arbiter_if.slave   i_bus,
    cache_mem_arbiter_if.slave   d_bus,
    cache_mem_arbiter_if.master  mem_bus
);

    lc3b_arb_state state_q;
    arb_burst_t    d_burst_q, d_burst_d;
    lc3b_word      mem_address_q;
    lc3b_data      mem_wdata_q;
    logic          mem_write_q;
    lc3b_mem_wmask mem_be_q;

    logic i_valid, d_valid, grant_i, grant_d;
    logic live_i, live_d;

    assign i_valid = i_bus.stb && i_bus.cyc;
    assign d_valid = d_bus.stb && d_bus.cyc;

    cache_arb_select #(.MAX_D_BURST(MAX_D_BURST)) u_select (
        .i_valid_i (i_valid),
        .d_valid_i (d_valid),
        .d_burst_i (d_burst_q),
        .grant_i_o (grant_i),
        .grant_d_o (grant_d)
    );

    // Burst only counts D grants that actually made I wait.
    always_comb begin
        d_burst_d = d_burst_q;
        if (state_q == ARB_IDLE) begin
            if (grant_d)
                d_burst_d = i_valid ? burst_inc(d_burst_q, BURST_W'(MAX_D_BURST)) : '0;
            else if (grant_i)
                d_burst_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            d_burst_q     <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_write_q   <= 1'b0;
            mem_be_q      <= '0;
        end else begin
            d_burst_q <= d_burst_d;
            case (state_q)
                ARB_IDLE: begin
                    if (grant_d) begin
                        mem_address_q <= d_bus.address;
                        mem_wdata_q   <= d_bus.wdata;
                        mem_write_q   <= d_bus.write;
                        mem_be_q      <= d_bus.byte_enable;
                        state_q       <= ARB_SERVE_D;
                    end else if (grant_i) begin
                        mem_address_q <= i_bus.address;
                        mem_wdata_q   <= '0;
                        mem_write_q   <= 1'b0;
                        mem_be_q      <= '1;
                        state_q       <= ARB_SERVE_I;
                    end
                end
                ARB_SERVE_I: begin
                    if (!i_bus.cyc || mem_bus.resp || mem_bus.retry)
                        state_q <= ARB_IDLE;
                end
                ARB_SERVE_D: begin
                    if (!d_bus.cyc || mem_bus.resp || mem_bus.retry)
                        state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // A granted requester dropping cyc kills the bus and swallows any completion that cycle.
    assign live_i = (state_q == ARB_SERVE_I) && i_bus.cyc;
    assign live_d = (state_q == ARB_SERVE_D) && d_bus.cyc;

    assign mem_bus.address     = mem_address_q;
    assign mem_bus.wdata       = mem_wdata_q;
    assign mem_bus.write       = mem_write_q;
    assign mem_bus.byte_enable = mem_be_q;
    assign mem_bus.stb         = live_i || live_d;
    assign mem_bus.cyc         = live_i || live_d;

    assign i_bus.rdata = mem_bus.rdata;
    assign i_bus.resp  = live_i && mem_bus.resp;
    assign i_bus.retry = live_i && mem_bus.retry;
    assign d_bus.rdata = mem_bus.rdata;
    assign d_bus.resp  = live_d && mem_bus.resp;
    assign d_bus.retry = live_d && mem_bus.retry;

    logic unused_i_side;
    assign unused_i_side = ^{i_bus.wdata, i_bus.write, i_bus.byte_enable};

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: arbitration, burst cap, retry, abort and async reset.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    cache_mem_arbiter_if i_bus ();
    cache_mem_arbiter_if d_bus ();
    cache_mem_arbiter_if mem_bus ();

    cache_mem_arbiter #(.MAX_D_BURST(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_bus   (i_bus),
        .d_bus   (d_bus),
        .mem_bus (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] LINE_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] LINE_B = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] WLINE  = 128'hA5A5_5A5A_F00D_CAFE_1234_5678_9ABC_DEF0;

    initial begin
        rst_n = 1'b0;
        i_bus.address = '0; i_bus.wdata = '0; i_bus.write = 1'b0; i_bus.byte_enable = '0;
        i_bus.stb = 1'b0; i_bus.cyc = 1'b0;
        d_bus.address = '0; d_bus.wdata = '0; d_bus.write = 1'b0; d_bus.byte_enable = '0;
        d_bus.stb = 1'b0; d_bus.cyc = 1'b0;
        mem_bus.rdata = LINE_B; mem_bus.resp = 1'b0; mem_bus.retry = 1'b0;

        // Reset state
        #12;
        chk("rst_mem_stb", 128'(mem_bus.stb), 128'd0);
        chk("rst_mem_cyc", 128'(mem_bus.cyc), 128'd0);
        chk("rst_mem_addr", 128'(mem_bus.address), 128'd0);
        chk("rst_mem_be", 128'(mem_bus.byte_enable), 128'd0);
        chk("rst_i_resp", 128'(i_bus.resp), 128'd0);
        chk("rst_d_retry", 128'(d_bus.retry), 128'd0);
        chk("rst_i_rdata", i_bus.rdata, LINE_B);
        chk("rst_state", 128'(dut.state_q), 128'(ARB_IDLE));
        chk("rst_burst", 128'(dut.d_burst_q), 128'd0);
        tick();
        rst_n = 1'b1;

        // Lone I read at 0x0040
        i_bus.address = 16'h0040; i_bus.stb = 1'b1; i_bus.cyc = 1'b1;
        #1;
        chk("t1_arb_cycle_stb", 128'(mem_bus.stb), 128'd0);
        tick();
        chk("t1_state", 128'(dut.state_q), 128'(ARB_SERVE_I));
        chk("t1_mem_stb", 128'(mem_bus.stb), 128'd1);
        chk("t1_mem_cyc", 128'(mem_bus.cyc), 128'd1);
        chk("t1_mem_addr", 128'(mem_bus.address), 128'h0040);
        chk("t1_mem_write", 128'(mem_bus.write), 128'd0);
        chk("t1_mem_be", 128'(mem_bus.byte_enable), 128'hFFFF);
        chk("t1_i_resp_wait", 128'(i_bus.resp), 128'd0);
        mem_bus.rdata = LINE_A; mem_bus.resp = 1'b1;
        #1;
        chk("t1_i_resp", 128'(i_bus.resp), 128'd1);
        chk("t1_i_rdata", i_bus.rdata, LINE_A);
        chk("t1_d_resp", 128'(d_bus.resp), 128'd0);
        tick();
        mem_bus.resp = 1'b0; i_bus.stb = 1'b0; i_bus.cyc = 1'b0;
        #1;
        chk("t1_idle", 128'(dut.state_q), 128'(ARB_IDLE));
        chk("t1_i_resp_drop", 128'(i_bus.resp), 128'd0);
        chk("t1_stb_drop", 128'(mem_bus.stb), 128'd0);

        // Simultaneous I@0x0100 and D write@0x2000: D first
        i_bus.address = 16'h0100; i_bus.stb = 1'b1; i_bus.cyc = 1'b1;
        d_bus.address = 16'h2000; d_bus.wdata = WLINE; d_bus.write = 1'b1;
        d_bus.byte_enable = 16'h0003; d_bus.stb = 1'b1; d_bus.cyc = 1'b1;
        tick();
        chk("t2_state_d", 128'(dut.state_q), 128'(ARB_SERVE_D));
        chk("t2_mem_addr", 128'(mem_bus.address), 128'h2000);
        chk("t2_mem_wdata", mem_bus.wdata, WLINE);
        chk("t2_mem_write", 128'(mem_bus.write), 128'd1);
        chk("t2_mem_be", 128'(mem_bus.byte_enable), 128'h0003);
        chk("t2_burst", 128'(dut.d_burst_q), 128'd1);
        mem_bus.resp = 1'b1;
        #1;
        chk("t2_d_resp", 128'(d_bus.resp), 128'd1);
        chk("t2_i_resp", 128'(i_bus.resp), 128'd0);
        chk("t2_d_rdata", d_bus.rdata, LINE_A);
        tick();
        mem_bus.resp = 1'b0; d_bus.stb = 1'b0; d_bus.cyc = 1'b0; d_bus.write = 1'b0;
        #1;
        chk("t2_gap_state", 128'(dut.state_q), 128'(ARB_IDLE));
        chk("t2_gap_stb", 128'(mem_bus.stb), 128'd0);
        tick();
        chk("t2_state_i", 128'(dut.state_q), 128'(ARB_SERVE_I));
        chk("t2_i_addr", 128'(mem_bus.address), 128'h0100);
        chk("t2_i_be", 128'(mem_bus.byte_enable), 128'hFFFF);
        chk("t2_i_write", 128'(mem_bus.write), 128'd0);
        chk("t2_i_wdata", mem_bus.wdata, 128'd0);
        chk("t2_burst_clr", 128'(dut.d_burst_q), 128'd0);
        mem_bus.resp = 1'b1;
        tick();
        mem_bus.resp = 1'b0; i_bus.stb = 1'b0; i_bus.cyc = 1'b0;

        // Burst cap: I held, D re-requests after every completion
        i_bus.address = 16'h0200; i_bus.stb = 1'b1; i_bus.cyc = 1'b1;
        d_bus.address = 16'h3000; d_bus.stb = 1'b1; d_bus.cyc = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t3_d_grant%0d", k), 128'(dut.state_q), 128'(ARB_SERVE_D));
            chk($sformatf("t3_burst%0d", k), 128'(dut.d_burst_q), 128'(k + 1));
            mem_bus.resp = 1'b1;
            tick();
            mem_bus.resp = 1'b0;
            d_bus.address = d_bus.address + 16'h0010;
        end
        tick();
        chk("t3_i_wins", 128'(dut.state_q), 128'(ARB_SERVE_I));
        chk("t3_i_addr", 128'(mem_bus.address), 128'h0200);
        chk("t3_burst_clr", 128'(dut.d_burst_q), 128'd0);
        mem_bus.resp = 1'b1;
        #1;
        chk("t3_i_resp", 128'(i_bus.resp), 128'd1);
        tick();
        mem_bus.resp = 1'b0; i_bus.stb = 1'b0; i_bus.cyc = 1'b0;
        d_bus.stb = 1'b0; d_bus.cyc = 1'b0;

        // mem_retry during SERVE_D leaves the burst count alone
        i_bus.address = 16'h0300; i_bus.stb = 1'b1; i_bus.cyc = 1'b1;
        d_bus.address = 16'h4000; d_bus.stb = 1'b1; d_bus.cyc = 1'b1;
        tick();
        chk("t4_state_d", 128'(dut.state_q), 128'(ARB_SERVE_D));
        mem_bus.retry = 1'b1;
        #1;
        chk("t4_d_retry", 128'(d_bus.retry), 128'd1);
        chk("t4_d_resp", 128'(d_bus.resp), 128'd0);
        chk("t4_i_retry", 128'(i_bus.retry), 128'd0);
        tick();
        mem_bus.retry = 1'b0; i_bus.stb = 1'b0; i_bus.cyc = 1'b0;
        #1;
        chk("t4_idle", 128'(dut.state_q), 128'(ARB_IDLE));
        chk("t4_burst_kept", 128'(dut.d_burst_q), 128'd1);
        chk("t4_retry_pulse", 128'(d_bus.retry), 128'd0);
        tick();
        chk("t4_reissue", 128'(dut.state_q), 128'(ARB_SERVE_D));
        chk("t4_reissue_addr", 128'(mem_bus.address), 128'h4000);
        mem_bus.resp = 1'b1;
        #1;
        chk("t4_reissue_resp", 128'(d_bus.resp), 128'd1);
        tick();
        mem_bus.resp = 1'b0; d_bus.stb = 1'b0; d_bus.cyc = 1'b0;

        // Abort: d_cyc dropped in the same cycle memory completes
        d_bus.address = 16'h5000; d_bus.stb = 1'b1; d_bus.cyc = 1'b1;
        tick();
        chk("t5_state_d", 128'(dut.state_q), 128'(ARB_SERVE_D));
        d_bus.cyc = 1'b0; mem_bus.resp = 1'b1;
        #1;
        chk("t5_d_resp_sup", 128'(d_bus.resp), 128'd0);
        chk("t5_mem_cyc", 128'(mem_bus.cyc), 128'd0);
        chk("t5_mem_stb", 128'(mem_bus.stb), 128'd0);
        tick();
        mem_bus.resp = 1'b0; d_bus.stb = 1'b0;
        chk("t5_idle", 128'(dut.state_q), 128'(ARB_IDLE));

        // Asynchronous reset in the middle of an I transaction
        i_bus.address = 16'h0600; i_bus.stb = 1'b1; i_bus.cyc = 1'b1;
        tick();
        chk("t6_state_i", 128'(dut.state_q), 128'(ARB_SERVE_I));
        chk("t6_mem_cyc_on", 128'(mem_bus.cyc), 128'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_mem_stb_off", 128'(mem_bus.stb), 128'd0);
        chk("t6_mem_cyc_off", 128'(mem_bus.cyc), 128'd0);
        chk("t6_mem_addr_clr", 128'(mem_bus.address), 128'd0);
        i_bus.stb = 1'b0; i_bus.cyc = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_state_idle", 128'(dut.state_q), 128'(ARB_IDLE));
        chk("t6_burst_zero", 128'(dut.d_burst_q), 128'd0);
        chk("t6_stb_idle", 128'(mem_bus.stb), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
